// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and the byte-level round transforms
// used by the iterative engine (column-major state, bit 0 = MSB of byte 0).
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  typedef logic [0:BLK_W-1] blk_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) plus the affine map
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      inv = gf_mul(inv, (i != 0) ? x : 8'h01);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = sub_byte(s[8*k +: 8]);
    end
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[8*(4*c+rw) +: 8] = s[8*(4*((c+rw)%4)+rw) +: 8];
      end
    end
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic blk_t add_round_key(input blk_t s, input blk_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] iState,
  input  logic [0:BLK_W-1] iRoundKey,
  input  logic             iFinal,
  output logic [0:BLK_W-1] oNext
);

  blk_t sub_s;
  blk_t shift_s;
  blk_t mix_s;
  blk_t pre_key_s;

  assign sub_s   = sub_bytes(iState);
  assign shift_s = shift_rows(sub_s);
  assign mix_s   = mix_columns(shift_s);

  // The last round of the cipher drops MixColumns
  always_comb begin
    if (iFinal) begin
      pre_key_s = shift_s;
    end else begin
      pre_key_s = mix_s;
    end
  end

  assign oNext = add_round_key(pre_key_s, iRoundKey);

endmodule

// File: rtl/aes_iter_round.sv
// Iterative AES encryption engine: one round per enabled clock, round keys
// fetched from an external store addressed by oKeyIdx.
module aes_iter_round
  import aes_pkg::*;
#(
  parameter int NR    = NR_128,
  parameter int IDX_W = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iClear,
  input  logic             iStart,
  input  logic [0:127]     iPlain,
  output logic [IDX_W-1:0] oKeyIdx,
  input  logic [0:127]     iRoundKey,
  output logic [0:127]     oState,
  output logic             oValid,
  input  logic             iReady,
  output logic             oBusy
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $error("aes_iter_round: NR must be 10, 12 or 14");
  end
  if (NR >= (1 << IDX_W)) begin : g_bad_idx_w
    $error("aes_iter_round: IDX_W too narrow for NR");
  end

  localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NR);
  localparam logic [IDX_W-1:0] RND_ONE  = IDX_W'(1);

  aes_state_e       state_r;
  logic [IDX_W-1:0] round_r;
  blk_t             blk_r;
  logic             valid_r;
  logic             busy_r;
  blk_t             load_s;
  blk_t             next_s;
  logic             final_s;

  assign final_s = (round_r == LAST_RND);
  assign load_s  = add_round_key(iPlain, iRoundKey);

  aes_round_dp u_dp (
    .iState   (blk_r),
    .iRoundKey(iRoundKey),
    .iFinal   (final_s),
    .oNext    (next_s)
  );

  // Outside RUN the store is pointed at key 0, ready for the initial whitening
  always_comb begin
    if (state_r == RUN) begin
      oKeyIdx = round_r;
    end else begin
      oKeyIdx = {IDX_W{1'b0}};
    end
  end

  // Control FSM, round counter and state register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r <= IDLE;
      round_r <= {IDX_W{1'b0}};
      blk_r   <= {BLK_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (iClear) begin
      state_r <= IDLE;
      round_r <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (iEn) begin
      case (state_r)
        IDLE: begin
          if (iStart) begin
            blk_r   <= load_s;
            round_r <= RND_ONE;
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          blk_r <= next_s;
          if (final_s) begin
            round_r <= {IDX_W{1'b0}};
            state_r <= DONE;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            round_r <= round_r + RND_ONE;
          end
        end
        DONE: begin
          // A start is only honoured when it coincides with the consumer taking the result
          if (valid_r && iReady) begin
            valid_r <= 1'b0;
            if (iStart) begin
              blk_r   <= load_s;
              round_r <= RND_ONE;
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          round_r <= {IDX_W{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign oState = blk_r;
  assign oValid = valid_r;
  assign oBusy  = busy_r;

endmodule
